// File: rtl/if_id_queue_pkg.sv
// Shared processor definitions used by the fetch/decode boundary queue:
// word width, default queue depth, the bubble value and the IF/ID entry type.
package if_id_queue_pkg;

  localparam int          WORD_W        = 32;
  localparam int          DEPTH_DEFAULT = 4;
  localparam logic [31:0] BUBBLE        = 32'd0;

  // One IF/ID pipeline-register entry: fetch PC (already PC+4) and instruction
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } if_id_t;

  // Replace an entry by a bubble when it is not valid
  function automatic if_id_t mask_entry(input logic vld, input if_id_t e);
    if_id_t r;
    r.pc    = vld ? e.pc    : BUBBLE;
    r.instr = vld ? e.instr : BUBBLE;
    return r;
  endfunction

endpackage

// File: rtl/queue_storage.sv
// DEPTH x 64-bit register array: one synchronous write port, one asynchronous
// read port. Contents are never reset or cleared.
module queue_storage
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  if_id_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output if_id_t                   rd_data
);

  if_id_t mem [DEPTH];

  // Write the entry presented by the fetch stage into its slot
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Show-ahead circular queue between fetch and decode. Holds DEPTH
// {PC, instruction} entries; the head entry is visible combinationally and a
// bubble is presented while the queue is empty. Flush (taken branch) clears
// only the control state; storage contents are left untouched.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       full,
  input  logic                       flush,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          do_push;
  logic          do_pop;
  if_id_t        wr_entry;
  if_id_t        head;
  if_id_t        head_out;

  // Status flags come straight from the registered occupancy
  assign out_valid = (occ != '0);
  assign full      = (occ == CW'(DEPTH));
  assign count     = occ;

  // Flush suppresses both transfers; full blocks a push even when popping
  assign do_push = in_valid && !full && !flush;
  assign do_pop  = pop && out_valid && !flush;

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  queue_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign head_out  = mask_entry(out_valid, head);
  assign out_pc    = head_out.pc;
  assign out_instr = head_out.instr;

  // Pointer and occupancy update; power-of-two DEPTH makes pointer wrap natural
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

endmodule
